sdram_req_queue: RTL and testbench

Client-side request queue that sits directly upstream of one SDRAM controller port and drives its addr/data/byte_en/wr/rd/burst signals. It buffers up to DEPTH read/write requests from a valid/ready client and issues them one at a time, in order. Each issued request waits for the controller's available/ready handshake. Read data comes back on a response strobe, so bus-facing logic (for example Apple II slot writes) never stalls on SDRAM refresh or arbitration.

---
 rtl/sdram_req_queue_pkg.sv | 22 ++
 rtl/sdram_req_queue_fifo.sv | 62 ++++++
 rtl/sdram_req_queue.sv | 124 ++++++++++++
 tb/tb_sdram_req_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_req_queue_pkg.sv
// Shared types for the SDRAM request queue: request payload and issue FSM states.
package sdram_req_pkg;

  localparam int unsigned PORT_ADDR_WIDTH   = 25;
  localparam int unsigned DATA_WIDTH        = 16;
  localparam int unsigned DQM_WIDTH         = 2;
  localparam int unsigned PORT_OUTPUT_WIDTH = 16;

  typedef struct packed {
    logic                       wr;
    logic                       burst;
    logic [PORT_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      data;
    logic [DQM_WIDTH-1:0]       byte_en;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_req_queue_fifo.sv
// Synchronous FIFO of SDRAM requests; head entry is always visible on o_head.
module sdram_req_fifo
  import sdram_req_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  req_t             i_din,
  input  logic             i_pop,
  output req_t             o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Buffers client read/write requests and issues them in order to one SDRAM
// controller port, returning read data on a one-cycle response strobe.
module sdram_req_queue
  import sdram_req_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic                         req_burst,
  input  logic [PORT_ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]        req_data,
  input  logic [DQM_WIDTH-1:0]         req_byte_en,
  output logic                         rsp_valid,
  output logic [PORT_OUTPUT_WIDTH-1:0] rsp_q,
  output logic [PORT_ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  output logic [DQM_WIDTH-1:0]         mem_byte_en,
  output logic                         mem_wr,
  output logic                         mem_rd,
  output logic                         mem_burst,
  input  logic                         mem_available,
  input  logic                         mem_ready,
  input  logic [PORT_OUTPUT_WIDTH-1:0] mem_q,
  output logic                         busy,
  output logic [LVL_W-1:0]             level
);

  state_t                       r_state;
  logic                         r_rsp_valid;
  logic [PORT_OUTPUT_WIDTH-1:0] r_rsp_q;
  logic [PORT_ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]        r_mem_data;
  logic [DQM_WIDTH-1:0]         r_mem_byte_en;
  logic                         r_mem_wr;
  logic                         r_mem_rd;
  logic                         r_mem_burst;

  req_t             w_din;
  req_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [LVL_W-1:0] w_level;

  assign w_din = '{wr: req_wr, burst: req_burst, addr: req_addr,
                   data: req_data, byte_en: req_byte_en};

  // Head leaves the queue only once the controller has completed it.
  assign w_pop = (r_state == WAIT) && mem_ready;

  sdram_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (req_valid),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign req_ready   = !w_full;
  assign level       = w_level;
  assign busy        = !w_empty || (r_state == WAIT);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_q       = r_rsp_q;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_byte_en = r_mem_byte_en;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign mem_burst   = r_mem_burst;

  // Issue FSM: strobes are single-cycle, command fields hold through WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_q       <= '0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_mem_byte_en <= '0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_burst   <= 1'b0;
    end else begin
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty && mem_available) begin
            r_mem_addr    <= w_head.addr;
            r_mem_data    <= w_head.data;
            r_mem_byte_en <= w_head.byte_en;
            r_mem_burst   <= w_head.burst;
            r_mem_wr      <= w_head.wr;
            r_mem_rd      <= !w_head.wr;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            r_state <= IDLE;
            if (!w_head.wr) begin
              r_rsp_q     <= mem_q;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: directed scenarios plus a random phase against a
// FIFO-ordered memory model and a behavioural controller with variable latency.
module tb_sdram_req_queue;
  import sdram_req_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_wr;
  logic                         req_burst;
  logic [PORT_ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]        req_data;
  logic [DQM_WIDTH-1:0]         req_byte_en;
  logic                         rsp_valid;
  logic [PORT_OUTPUT_WIDTH-1:0] rsp_q;
  logic [PORT_ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]        mem_data;
  logic [DQM_WIDTH-1:0]         mem_byte_en;
  logic                         mem_wr;
  logic                         mem_rd;
  logic                         mem_burst;
  logic                         mem_available;
  logic                         mem_ready;
  logic [PORT_OUTPUT_WIDTH-1:0] mem_q;
  logic                         busy;
  logic [LVL_W-1:0]             level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_req_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_burst     (req_burst),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_byte_en   (req_byte_en),
    .rsp_valid     (rsp_valid),
    .rsp_q         (rsp_q),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_byte_en   (mem_byte_en),
    .mem_wr        (mem_wr),
    .mem_rd        (mem_rd),
    .mem_burst     (mem_burst),
    .mem_available (mem_available),
    .mem_ready     (mem_ready),
    .mem_q         (mem_q),
    .busy          (busy),
    .level         (level)
  );

  typedef struct {
    logic        wr;
    logic        burst;
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [15:0] exp_rsp[$];
  logic [15:0] ref_mem  [logic [24:0]];
  logic [15:0] ctrl_mem [logic [24:0]];

  logic        m_out   = 1'b0;
  int          n_rsp   = 0;
  logic [15:0] last_rsp = '0;

  int          lat    = 4;
  logic        c_busy = 1'b0;
  int          c_cnt  = 0;
  logic [15:0] c_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [24:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E37;
    return t[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r[15:8] = be[1] ? n[15:8] : o[15:8];
    r[7:0]  = be[0] ? n[7:0]  : o[7:0];
    return r;
  endfunction

  function automatic logic [15:0] ref_read(input logic [24:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ctrl_read(input logic [24:0] a);
    return ctrl_mem.exists(a) ? ctrl_mem[a] : init_word(a);
  endfunction

  // Reference model + monitor, sampled on the falling edge.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_valid && req_ready) begin
          c.wr = req_wr; c.burst = req_burst; c.addr = req_addr;
          c.data = req_data; c.be = req_byte_en;
          exp_cmd.push_back(c);
          if (req_wr) ref_mem[req_addr] = merge(ref_read(req_addr), req_data, req_byte_en);
          else        exp_rsp.push_back(ref_read(req_addr));
        end
        if (mem_wr || mem_rd) begin
          chk("strobe_while_outstanding", 32'(m_out), 0);
          m_out = 1'b1;
          if (exp_cmd.size() == 0) begin
            chk("strobe_unexpected", 32'({mem_wr, mem_rd}), 0);
          end else begin
            c = exp_cmd.pop_front();
            chk("cmd_wr", 32'(mem_wr), 32'(c.wr));
            chk("cmd_rd", 32'(mem_rd), 32'(!c.wr));
            chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
            chk("cmd_data", 32'(mem_data), 32'(c.data));
            chk("cmd_byte_en", 32'(mem_byte_en), 32'(c.be));
            chk("cmd_burst", 32'(mem_burst), 32'(c.burst));
          end
        end
        if (mem_ready) m_out = 1'b0;
        if (rsp_valid) begin
          n_rsp++;
          last_rsp = rsp_q;
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
          else                     chk("rsp_q", 32'(rsp_q), 32'(exp_rsp.pop_front()));
        end
      end
    end
  end

  // Behavioural controller: completes each strobe after 'lat' cycles.
  initial begin
    mem_ready = 1'b0;
    mem_q     = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (c_busy) begin
        if (c_cnt <= 1) begin
          mem_ready = 1'b1;
          mem_q     = c_data;
          c_busy    = 1'b0;
        end else begin
          c_cnt--;
        end
      end
      if (reset_n && (mem_wr || mem_rd)) begin
        c_busy = 1'b1;
        c_cnt  = lat;
        if (mem_wr) ctrl_mem[mem_addr] = merge(ctrl_read(mem_addr), mem_data, mem_byte_en);
        else        c_data = ctrl_read(mem_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic wr, input logic burst, input logic [24:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_burst = burst;
    req_addr = a; req_data = d; req_byte_en = be;
    while (!req_ready && n < 300) begin
      mem_available = 1'b1;
      step();
      n++;
    end
    chk("push_accepted", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!(mem_wr || mem_rd) && n < 300) begin step(); n++; end
    chk(tag, 32'(mem_wr || mem_rd), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || c_busy || exp_cmd.size() != 0) && n < 2000) begin step(); n++; end
    chk(tag, 32'(busy), 0);
    chk({tag, "_cmds_left"}, 32'(exp_cmd.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_q"}, 32'(rsp_q), 0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_burst"}, 32'(mem_burst), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_mem_byte_en"}, 32'(mem_byte_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_level"}, 32'(level), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   rsp0;
    logic saw;
    reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
    req_addr = '0; req_data = '0; req_byte_en = '0; mem_available = 1'b0;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk); reset_n = 1'b1;
    step();

    // Single read with controller latency 4.
    ctrl_mem[25'h0001234] = 16'hBEEF;
    ref_mem[25'h0001234]  = 16'hBEEF;
    lat = 4; mem_available = 1'b1;
    push(1'b0, 1'b0, 25'h0001234, 16'h0000, 2'b00);
    chk("t1_level", 32'(level), 1);
    chk("t1_no_early_rd", 32'(mem_rd), 0);
    step();
    chk("t1_mem_rd", 32'(mem_rd), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0001234);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin step(); cyc++; end
    chk("t1_rsp_latency", 32'(cyc), 5);
    chk("t1_rsp_q", 32'(rsp_q), 32'hBEEF);
    chk("t1_busy_after", 32'(busy), 0);
    step();
    chk("t1_rsp_one_cycle", 32'(rsp_valid), 0);

    // Write then read at one address: read must observe the write.
    rsp0 = n_rsp; lat = 2;
    push(1'b1, 1'b0, 25'h000ABCD, 16'hA5A5, 2'b11);
    push(1'b0, 1'b0, 25'h000ABCD, 16'h0000, 2'b00);
    wait_idle("t2_idle");
    step();
    chk("t2_rsp_count", 32'(n_rsp - rsp0), 1);
    chk("t2_read_new_data", 32'(last_rsp), 32'hA5A5);

    // Fill with the controller unavailable.
    mem_available = 1'b0; lat = 3;
    push(1'b0, 1'b0, 25'h0000100, 16'h0000, 2'b00);
    push(1'b1, 1'b0, 25'h0000101, 16'h1111, 2'b10);
    push(1'b0, 1'b0, 25'h0000101, 16'h0000, 2'b00);
    push(1'b1, 1'b0, 25'h0000102, 16'h2222, 2'b01);
    chk("t3_level_full", 32'(level), 4);
    chk("t3_not_ready", 32'(req_ready), 0);
    req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b0;
    req_addr = 25'h0000104; req_data = '0; req_byte_en = '0;
    step(); step();
    chk("t3_still_not_ready", 32'(req_ready), 0);
    mem_available = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin step(); cyc++; end
    chk("t3_ready_after_pop", 32'(req_ready), 1);
    chk("t3_level_after_pop", 32'(level), 3);
    chk("t3_pop_same_cycle_rsp", 32'(rsp_valid), 1);
    step();
    req_valid = 1'b0;
    chk("t3_level_after_push", 32'(level), 4);
    wait_idle("t3_idle");

    // Long stall: command held, availability toggling ignored.
    lat = 20; mem_available = 1'b1;
    push(1'b1, 1'b0, 25'h0002222, 16'h1357, 2'b01);
    push(1'b0, 1'b0, 25'h0003333, 16'h0000, 2'b00);
    wait_strobe("t4_strobe");
    for (int i = 0; i < 18; i++) begin
      mem_available = 1'($urandom);
      step();
      chk("t4_hold_addr", 32'(mem_addr), 32'h0002222);
      chk("t4_hold_data", 32'(mem_data), 32'h1357);
      chk("t4_hold_be", 32'(mem_byte_en), 32'h1);
      chk("t4_no_strobe", 32'({mem_wr, mem_rd}), 0);
    end
    mem_available = 1'b1;
    wait_idle("t4_idle");

    // Reset while a read is outstanding with three entries held.
    lat = 10;
    push(1'b0, 1'b0, 25'h0000400, 16'h0000, 2'b00);
    push(1'b0, 1'b0, 25'h0000401, 16'h0000, 2'b00);
    push(1'b0, 1'b0, 25'h0000402, 16'h0000, 2'b00);
    chk("t5_level_before", 32'(level), 3);
    chk("t5_busy_before", 32'(busy), 1);
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t5_in_reset");
    exp_cmd.delete(); exp_rsp.delete(); m_out = 1'b0;
    step(); step();
    @(negedge clk); reset_n = 1'b1;
    saw = 1'b0; cyc = 0;
    while ((c_busy || cyc < 4) && cyc < 100) begin
      step(); cyc++;
      if (rsp_valid || mem_rd || mem_wr) saw = 1'b1;
    end
    chk("t5_no_late_activity", 32'(saw), 0);
    chk("t5_level_after", 32'(level), 0);
    chk("t5_busy_after", 32'(busy), 0);

    // Burst read forwards the burst flag and full-width data.
    ctrl_mem[25'h000F00F] = 16'hC3A7;
    ref_mem[25'h000F00F]  = 16'hC3A7;
    lat = 3;
    push(1'b0, 1'b1, 25'h000F00F, 16'h0000, 2'b00);
    wait_strobe("t6_strobe");
    chk("t6_mem_burst", 32'(mem_burst), 1);
    chk("t6_mem_rd", 32'(mem_rd), 1);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin step(); cyc++; end
    chk("t6_rsp_q", 32'(rsp_q), 32'hC3A7);
    wait_idle("t6_idle");

    // Random traffic over a small address window to provoke RAW hazards.
    for (int i = 0; i < 80; i++) begin
      lat = 1 + int'($urandom % 5);
      mem_available = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) step();
      push(1'($urandom), 1'($urandom), 25'h1000 + 25'($urandom % 8),
           16'($urandom), 2'($urandom));
    end
    mem_available = 1'b1;
    wait_idle("rand_idle");
    step(); step();
    chk("rand_rsp_left", 32'(exp_rsp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
